// File: rtl/wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wrr_arbiter
// Description : N-way weighted round-robin arbiter with per-requester beat
//               budgets and zero-bubble handover between holders.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [N-1:0]    req_vld,
  input  logic [N*CW-1:0] weight,
  output logic [N-1:0]    o_grant,
  output logic            o_grant_vld,
  output logic [IW-1:0]   o_grant_id
);

  localparam logic [IW-1:0] c_last_id = IW'(N - 1);
  localparam logic [IW:0]   c_n       = (IW + 1)'(N);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_grant, w_grant_nxt;
  logic [IW-1:0]  r_id, w_id_nxt;
  logic [IW-1:0]  r_ptr, w_ptr_nxt;
  logic [CW-1:0]  r_cr, w_cr_nxt;

  logic [CW-1:0]  w_wt [N];
  logic [CW-1:0]  w_load;
  logic [IW-1:0]  w_release_ptr;
  logic [IW-1:0]  w_scan_ptr;
  logic [IW-1:0]  w_win;
  logic [IW:0]    w_sum;
  logic           w_any;
  logic           w_release;

  for (genvar gi = 0; gi < N; gi++) begin : g_wt
    assign w_wt[gi] = weight[gi*CW +: CW];
  end

  // On release the scan starts just past the holder, so the search runs in
  // the same edge as the release and the next holder follows without a gap.
  assign w_release_ptr = (r_id == c_last_id) ? '0 : r_id + IW'(1);
  assign w_scan_ptr    = (r_state == S_GRANT) ? w_release_ptr : r_ptr;
  assign w_release     = (r_state == S_GRANT) &&
                         (!req_vld[r_id] || (r_cr == CW'(1)));

  // Scan from the highest offset down so the nearest requester wins last.
  always_comb begin : p_search
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_scan_ptr} + (IW + 1)'(k);
      if (w_sum >= c_n) begin
        w_sum = w_sum - c_n;
      end
      if (req_vld[w_sum[IW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_sum[IW-1:0];
      end
    end
  end

  assign w_load = (w_wt[w_win] == '0) ? CW'(1) : w_wt[w_win];

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_id_nxt    = r_id;
    w_cr_nxt    = r_cr;
    w_ptr_nxt   = r_ptr;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_grant_nxt = '0;
      w_id_nxt    = '0;
      w_cr_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            w_state_nxt = S_GRANT;
            w_grant_nxt = N'(1) << w_win;
            w_id_nxt    = w_win;
            w_cr_nxt    = w_load;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            w_ptr_nxt = w_release_ptr;
            if (w_any) begin
              w_grant_nxt = N'(1) << w_win;
              w_id_nxt    = w_win;
              w_cr_nxt    = w_load;
            end else begin
              w_state_nxt = S_IDLE;
              w_grant_nxt = '0;
              w_id_nxt    = '0;
              w_cr_nxt    = '0;
            end
          end else begin
            w_cr_nxt = r_cr - CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_id_nxt    = '0;
          w_cr_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (!rstn) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_cr    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_id    <= w_id_nxt;
      r_cr    <= w_cr_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_id  = r_id;
  assign o_grant_vld = (r_state == S_GRANT);

endmodule
`default_nettype wire
